// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
//
// Run-time programmable clock-divider controller. It accepts divide-ratio
// requests over a valid/ready handshake and starts or stops the divided clock
// on request. A new ratio is only applied at a period boundary, so clk_out
// never produces a runt pulse. A one-cycle tick marks every rising edge of
// the divided clock.
//
// Parameters:
//   CNT_W    - width of the divide ratio and of the period counter
//   DEF_DIV  - divide ratio loaded at reset (must be >= 2)
//
// Ports:
//   clk_in      in   the only clock (rising edge, plus optional negedge stage)
//   rst         in   asynchronous, active-high reset
//   run         in   level: 1 = generate divided clock, 0 = stop at period end
//   cfg_valid   in   a divide-ratio request is present
//   cfg_div     in   requested ratio N
//   cfg_ready   out  a request can be accepted this cycle
//   cfg_err     out  one-cycle pulse after a rejected (N < 2) request
//   clk_out     out  divided clock
//   tick        out  one-cycle pulse in the cycle clk_out rises
//   div_active  out  ratio currently in effect
//   busy        out  1 while running or draining
//
// Optional feature macro: CLK_DIV_CTRL_ODD50_EN
//   When defined, odd ratios get a true 50 % duty cycle by stretching the
//   high phase with a negedge register by half an input period.
// ---------------------------------------------------------------------------
module clk_div_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             bad_req;
  logic             good_xfer;
  logic             at_end;
  logic [CNT_W:0]   half_d;

  assign cfg_ready  = ~pend_vld_q;
  assign xfer       = cfg_valid & cfg_ready;
  assign bad_req    = (cfg_div < CNT_W'(2));
  assign good_xfer  = xfer & ~bad_req;
  assign at_end     = (cnt_q == (div_q - CNT_W'(1)));

  // Length of the high phase for the ratio governing the next count value.
  // Without the odd-50 stage this is ceil(N/2); with it, floor(N/2) and the
  // negedge stage adds the missing half cycle for odd N.
`ifdef CLK_DIV_CTRL_ODD50_EN
  assign half_d = {1'b0, div_d} >> 1;
`else
  assign half_d = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
`endif

  // Next-state logic: period counting, ratio application at the wrap, and
  // pending-ratio bookkeeping. A request accepted in the last cycle of a
  // period bypasses the pending register and governs the very next period.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = xfer & bad_req;

    case (state_q)
      ST_STOP: begin
        cnt_d = '0;
        if (good_xfer) begin
          div_d = cfg_div;
        end
        if (run) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (at_end) begin
          cnt_d = '0;
          if (good_xfer) begin
            div_d = cfg_div;
          end else if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
          end
          state_d = run ? ST_RUN : ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (good_xfer) begin
            pend_d     = cfg_div;
            pend_vld_d = 1'b1;
          end
          if ((state_q == ST_RUN) && !run) begin
            state_d = ST_DRAIN;
          end
        end
      end

      default: begin
        state_d = ST_STOP;
        cnt_d   = '0;
      end
    endcase

    clk_d  = (state_d != ST_STOP) && ({1'b0, cnt_d} < half_d);
    tick_d = clk_d & ~clk_q;
  end

  // State and output registers; reset drops clk_out immediately.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= ST_STOP;
      cnt_q      <= '0;
      div_q      <= CNT_W'(DEF_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

`ifdef CLK_DIV_CTRL_ODD50_EN
  logic neg_q;

  // Half-cycle delayed copy of the high phase, only for odd ratios; ORing it
  // in moves the falling edge later while leaving the rising edge untouched.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= clk_q & div_q[0];
    end
  end

  assign clk_out = clk_q | neg_q;
`else
  assign clk_out = clk_q;
`endif

  assign tick       = tick_q;
  assign cfg_err    = err_q;
  assign div_active = div_q;
  assign busy       = (state_q != ST_STOP);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
//
// Directed testbench for clk_div_ctrl (default build, CNT_W = 8,
// DEF_DIV = 4). Inputs change and outputs are sampled 1 time unit after each
// rising edge of clk_in. The scenarios run back to back, so each task starts
// where the previous one left the period counter.
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             clk_in;
  logic             rst;
  logic             run;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_active;
  logic             busy;

  int vectors;
  int miscompares;

  clk_div_ctrl #(
    .CNT_W   (CNT_W),
    .DEF_DIV (4)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .run        (run),
    .cfg_valid  (cfg_valid),
    .cfg_div    (cfg_div),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active),
    .busy       (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step();
    step();
    rst = 1'b0;
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_clk_out: got %0b expected 0", clk_out); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tick: got %0b expected 0", tick); end
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cfg_err: got %0b expected 0", cfg_err); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (div_active !== 8'd4) begin miscompares++; $display("[TB] FAIL reset_div_active: got %0d expected 4", div_active); end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %0b expected 0", busy); end
  endtask

  // DEF_DIV = 4: clk_out 1,1,0,0 repeating, tick on each first high cycle.
  task automatic test_run_div4();
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    exp_clk  = 8'b1100_1100;
    exp_tick = 8'b1000_1000;
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      vectors++; if (clk_out !== exp_clk[7-i]) begin miscompares++; $display("[TB] FAIL div4_clk_out[%0d]: got %0b expected %0b", i, clk_out, exp_clk[7-i]); end
      vectors++; if (tick !== exp_tick[7-i]) begin miscompares++; $display("[TB] FAIL div4_tick[%0d]: got %0b expected %0b", i, tick, exp_tick[7-i]); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL div4_busy[%0d]: got %0b expected 1", i, busy); end
    end
  endtask

  // Enters at cnt = 3 of N = 4; accepts N = 6 at cnt = 1.
  task automatic test_ratio_change();
    step();
    step();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL chg_ready_before: got %0b expected 1", cfg_ready); end
    step();
    cfg_valid = 1'b0;
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL chg_ready_pending: got %0b expected 0", cfg_ready); end
    vectors++; if (div_active !== 8'd4) begin miscompares++; $display("[TB] FAIL chg_div_old: got %0d expected 4", div_active); end
    step();
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL chg_ready_pending2: got %0b expected 0", cfg_ready); end
    step();
    vectors++; if (div_active !== 8'd6) begin miscompares++; $display("[TB] FAIL chg_div_new: got %0d expected 6", div_active); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL chg_ready_after: got %0b expected 1", cfg_ready); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL chg_tick_wrap: got %0b expected 1", tick); end
    vectors++; if (clk_out !== 1'b1) begin miscompares++; $display("[TB] FAIL chg_clk_wrap: got %0b expected 1", clk_out); end
    for (int i = 1; i < 6; i++) begin
      step();
      vectors++; if (clk_out !== (i < 3)) begin miscompares++; $display("[TB] FAIL div6_clk_out[%0d]: got %0b expected %0b", i, clk_out, (i < 3)); end
      vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL div6_tick[%0d]: got %0b expected 0", i, tick); end
    end
    step();
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL div6_tick_period: got %0b expected 1", tick); end
  endtask

  // Enters at cnt = 0 of N = 6; accepts N = 5 in the cnt = 5 cycle.
  task automatic test_odd_at_boundary();
    for (int i = 0; i < 5; i++) step();
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL odd_clk_last: got %0b expected 0", clk_out); end
    cfg_valid = 1'b1; cfg_div = 8'd5;
    step();
    cfg_valid = 1'b0;
    vectors++; if (div_active !== 8'd5) begin miscompares++; $display("[TB] FAIL odd_div: got %0d expected 5", div_active); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL odd_ready: got %0b expected 1", cfg_ready); end
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL odd_tick_wrap: got %0b expected 1", tick); end
    for (int i = 1; i < 5; i++) begin
      step();
      vectors++; if (clk_out !== (i < 3)) begin miscompares++; $display("[TB] FAIL div5_clk_out[%0d]: got %0b expected %0b", i, clk_out, (i < 3)); end
    end
    step();
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL div5_tick_period: got %0b expected 1", tick); end
  endtask

  // Enters at cnt = 0 of N = 5; N = 1 and N = 0 are both rejected.
  task automatic test_reject();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("[TB] FAIL rej1_err: got %0b expected 1", cfg_err); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rej1_ready: got %0b expected 1", cfg_ready); end
    step();
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rej1_err_end: got %0b expected 0", cfg_err); end
    cfg_valid = 1'b1; cfg_div = 8'd0;
    step();
    cfg_valid = 1'b0;
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("[TB] FAIL rej0_err: got %0b expected 1", cfg_err); end
    step();
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rej0_err_end: got %0b expected 0", cfg_err); end
    vectors++; if (div_active !== 8'd5) begin miscompares++; $display("[TB] FAIL rej_div_kept: got %0d expected 5", div_active); end
  endtask

  // Enters at cnt = 4 of N = 5; switches to N = 8, drops run at cnt = 1,
  // then exercises the handshake while stopped.
  task automatic test_drain();
    cfg_valid = 1'b1; cfg_div = 8'd8;
    step();
    cfg_valid = 1'b0;
    vectors++; if (div_active !== 8'd8) begin miscompares++; $display("[TB] FAIL drain_div: got %0d expected 8", div_active); end
    step();
    run = 1'b0;
    for (int i = 2; i < 8; i++) begin
      step();
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_busy[%0d]: got %0b expected 1", i, busy); end
      vectors++; if (clk_out !== (i < 4)) begin miscompares++; $display("[TB] FAIL drain_clk_out[%0d]: got %0b expected %0b", i, clk_out, (i < 4)); end
    end
    step();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_busy: got %0b expected 0", busy); end
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_clk_out: got %0b expected 0", clk_out); end
    step();
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_tick: got %0b expected 0", tick); end
    cfg_valid = 1'b1; cfg_div = 8'd1;
    step();
    cfg_valid = 1'b0;
    vectors++; if (cfg_err !== 1'b1) begin miscompares++; $display("[TB] FAIL stop_rej_err: got %0b expected 1", cfg_err); end
    step();
    vectors++; if (cfg_err !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_rej_err_end: got %0b expected 0", cfg_err); end
    cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    vectors++; if (div_active !== 8'd3) begin miscompares++; $display("[TB] FAIL stop_load_div: got %0d expected 3", div_active); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stop_load_busy: got %0b expected 0", busy); end
  endtask

  // Runs N = 3, leaves N = 7 pending, then resets in mid-period.
  task automatic test_reset_midperiod();
    run = 1'b1;
    step();
    vectors++; if (tick !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_start_tick: got %0b expected 1", tick); end
    cfg_valid = 1'b1; cfg_div = 8'd7;
    step();
    cfg_valid = 1'b0;
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_pending_ready: got %0b expected 0", cfg_ready); end
    vectors++; if (clk_out !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_pre_clk_out: got %0b expected 1", clk_out); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_clk_out: got %0b expected 0", clk_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy: got %0b expected 0", busy); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_ready: got %0b expected 1", cfg_ready); end
    vectors++; if (div_active !== 8'd4) begin miscompares++; $display("[TB] FAIL rm_div: got %0d expected 4", div_active); end
    vectors++; if (tick !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_tick: got %0b expected 0", tick); end
    run = 1'b0;
    @(negedge clk_in);
    rst = 1'b0;
    step();
    vectors++; if (div_active !== 8'd4) begin miscompares++; $display("[TB] FAIL rm_div_after: got %0d expected 4", div_active); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy_after: got %0b expected 0", busy); end
    vectors++; if (clk_out !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_clk_after: got %0b expected 0", clk_out); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_run_div4();
    test_ratio_change();
    test_odd_at_boundary();
    test_reject();
    test_drain();
    test_reset_midperiod();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
